// File: rtl/uart_pkg.sv
// uart_pkg: parity encodings, default bit timing and FSM states shared by the UART transmitter and receiver
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} uart_state_t;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake into the UART transmitter
interface uart_tx_if;
  logic tx_valid;
  logic [7:0] tx_data;
  logic tx_ready;
  modport master(output tx_valid, output tx_data, input tx_ready);
  modport slave(input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with a bit_end strobe on its terminal count
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign bit_end = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clear || bit_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: one-entry holding register feeding a start/8N/parity/stop serialiser
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic rst,
  uart_tx_if.slave tx,
  output logic tx_serial,
  output logic tx_busy,
  output logic tx_done
);
  uart_state_t state;
  logic [7:0] hold, shift;
  logic [2:0] idx;
  logic hold_full, stop_cnt, bit_end, line, last_stop;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
    .clk(clk),
    .rst(rst),
    .clear(state == IDLE),
    .bit_end(bit_end)
  );
  assign tx.tx_ready = !hold_full;
  assign last_stop = state == STOP && bit_end && stop_cnt == 1'(STOP_BITS - 1);
  // outputs are registered from the current state, so the line trails the FSM by one cycle
  always_comb
    line = state == START ? 1'b0 :
           state == DATA  ? shift[idx] :
           state == PAR   ? (PARITY == PARITY_ODD ? ~^shift : ^shift) : 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      hold <= '0;
      shift <= '0;
      idx <= '0;
      hold_full <= 1'b0;
      stop_cnt <= 1'b0;
      tx_serial <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_serial <= line;
      tx_busy <= state != IDLE;
      tx_done <= last_stop;
      if (tx.tx_valid && !hold_full) begin
        hold <= tx.tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE:
          if (hold_full) begin
            shift <= hold;
            hold_full <= 1'b0;
            state <= START;
          end
        START:
          if (bit_end) begin
            idx <= '0;
            state <= DATA;
          end
        DATA:
          if (bit_end) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= PARITY != PARITY_NONE ? PAR : STOP;
          end
        PAR:
          if (bit_end) state <= STOP;
        STOP:
          if (last_stop) begin
            stop_cnt <= 1'b0;
            // a waiting byte starts its frame straight after the stop bit
            if (hold_full) begin
              shift <= hold;
              hold_full <= 1'b0;
              state <= START;
            end else state <= IDLE;
          end else if (bit_end) stop_cnt <= 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitter configurations checked against a per-frame line model
module tb_uart_tx;
  localparam int N = 8;
  localparam int PAR_CFG [3] = '{0, 2, 1};
  localparam int STOP_CFG [3] = '{1, 2, 1};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid [3];
  logic rdy [3];
  logic ser [3];
  logic busy [3];
  logic done [3];
  logic [7:0] data [3];
  logic [7:0] q [3][$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit act [3], post [3], bad [3];
  int pos [3], bad_pos [3], done_cyc [3], done_prev [3];
  logic [11:0] cur [3];
  logic [7:0] cur_b [3];
  logic [2:0] bad_got [3], bad_exp [3];
  logic ed, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_if ifc ();
    assign ifc.tx_valid = valid[g];
    assign ifc.tx_data = data[g];
    assign rdy[g] = ifc.tx_ready;
    uart_tx #(.CLKS_PER_BIT(N), .PARITY(PAR_CFG[g]), .STOP_BITS(STOP_CFG[g])) dut (
      .clk(clk),
      .rst(rst),
      .tx(ifc),
      .tx_serial(ser[g]),
      .tx_busy(busy[g]),
      .tx_done(done[g])
    );
  end

  function automatic int flen(int k);
    return 10 + (PAR_CFG[k] != 0 ? 1 : 0) + STOP_CFG[k] - 1;
  endfunction

  // line bits LSB first: start, data, optional parity, then ones for stop bits
  function automatic logic [11:0] frame(int k, logic [7:0] b);
    logic [11:0] f;
    int ones;
    f = '1;
    ones = $countones(b);
    f[0] = 1'b0;
    f[8:1] = b;
    if (PAR_CFG[k] == 1) f[9] = (ones % 2 == 0);
    else if (PAR_CFG[k] == 2) f[9] = (ones % 2 == 1);
    return f;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic send(int k, logic [7:0] b, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    valid[k] = 1'b1;
    data[k] = b;
    while (!rdy[k] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept_wait_dut%0d", k), n < 1000, 1);
    q[k].push_back(b);
    @(posedge clk);
    #1;
    acc = cyc;
    valid[k] = 1'b0;
    data[k] = 8'($urandom);
  endtask

  function automatic bit pending();
    for (int k = 0; k < 3; k++) if (q[k].size() != 0 || act[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (pending() && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", n < 5000, 1);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        act[k] = 1'b0;
        post[k] = 1'b0;
      end else begin
        if (!act[k]) begin
          if (post[k] && ser[k] === 1'b1) chk($sformatf("busy_fall_dut%0d", k), {busy[k], done[k]}, 0);
          post[k] = 1'b0;
          if (ser[k] === 1'b0) begin
            act[k] = 1'b1;
            pos[k] = 0;
            bad[k] = 1'b0;
            if (q[k].size() == 0) begin
              cur_b[k] = 8'h00;
              cur[k] = '1;
              bad[k] = 1'b1;
              bad_pos[k] = 0;
              bad_got[k] = 3'b0;
              bad_exp[k] = 3'b111;
            end else begin
              cur_b[k] = q[k].pop_front();
              cur[k] = frame(k, cur_b[k]);
            end
          end
        end
        if (act[k]) begin
          eb = cur[k][pos[k] / N];
          ed = pos[k] == flen(k) * N - 1;
          if (!bad[k] && (ser[k] !== eb || busy[k] !== 1'b1 || done[k] !== ed)) begin
            bad[k] = 1'b1;
            bad_pos[k] = pos[k];
            bad_got[k] = {ser[k], busy[k], done[k]};
            bad_exp[k] = {eb, 1'b1, ed};
          end
          if (done[k] === 1'b1) begin
            done_prev[k] = done_cyc[k];
            done_cyc[k] = cyc;
          end
          pos[k]++;
          if (pos[k] == flen(k) * N) begin
            act[k] = 1'b0;
            post[k] = 1'b1;
            vectors++;
            if (bad[k]) begin
              miscompares++;
              $display("FAIL frame dut%0d byte %02h: cycle %0d of frame, line/busy/done got %03b, expected %03b",
                       k, cur_b[k], bad_pos[k], bad_got[k], bad_exp[k]);
            end
          end
        end
      end
    end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, a2, gap;
    logic [7:0] b;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b0;
      data[k] = 8'h00;
      done_cyc[k] = 0;
      done_prev[k] = 0;
    end
    #50 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ser%0d", k), ser[k], 1);
      chk($sformatf("rst_busy%0d", k), busy[k], 0);
      chk($sformatf("rst_ready%0d", k), rdy[k], 1);
      chk($sformatf("rst_done%0d", k), done[k], 0);
    end
    // single byte, handshake and start-edge timing
    send(0, 8'h41, a);
    chk("ready_drop", rdy[0], 0);
    @(posedge clk);
    #1;
    chk("ser_high_t1", ser[0], 1);
    chk("ready_back_t1", rdy[0], 1);
    @(posedge clk);
    #1;
    chk("ser_fall_t2", ser[0], 0);
    wait_idle();
    chk("done_latency_41", done_cyc[0] - a, 10 * N + 1);
    // back-to-back, second byte accepted during the first start bit
    send(0, 8'hA5, a);
    send(0, 8'h3C, a2);
    chk("b2b_accept_gap", a2 - a, 2);
    wait_idle();
    chk("b2b_done_spacing", done_cyc[0] - done_prev[0], 10 * N);
    // even parity, two stop bits, data changed after acceptance
    send(1, 8'h07, a);
    send(1, 8'h12, a2);
    data[1] = 8'hFF;
    wait_idle();
    chk("even2_done_latency", done_prev[1] - a, 12 * N + 1);
    chk("even2_done_spacing", done_cyc[1] - done_prev[1], 12 * N);
    // odd parity
    send(2, 8'h07, a);
    send(2, 8'h55, a2);
    wait_idle();
    chk("odd_done_spacing", done_cyc[2] - done_prev[2], 11 * N);
    // asynchronous reset during data bit 3 with a second byte held
    send(0, 8'hC3, a);
    send(0, 8'h99, a2);
    while (cyc < a + 2 + 4 * N + N / 2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ser", ser[0], 1);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_ready", rdy[0], 1);
    chk("midrst_done", done[0], 0);
    for (int k = 0; k < 3; k++) q[k].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(0, 8'h5A, a);
    wait_idle();
    chk("post_rst_latency", done_cyc[0] - a, 10 * N + 1);
    // random traffic across all three configurations
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      send($urandom_range(2, 0), b, a);
      gap = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(40, 0);
      repeat (gap) @(negedge clk);
    end
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
